// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer slave on the CPU data-memory bus.
// Registers: CTRL (EN/MODE/IM), PRESET, COUNT (read-only). Raises irq on expiry.
module bus_timer #(
  parameter int WIDTH     = 32,
  parameter int CTRL_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam int EN_B = 0;
  localparam int IM_B = 3;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t               state, state_nxt;
  logic [CTRL_BITS-1:0] ctrl_q, ctrl_eff, ctrl_nxt;
  logic [WIDTH-1:0]     preset_q, count_q, count_nxt;
  logic                 irq_flag, flag_nxt;
  logic                 wr_ctrl, wr_preset;
  logic                 en_eff, auto_eff, auto_q;

  assign wr_ctrl   = sel & we & (addr == 2'd0);
  assign wr_preset = sel & we & (addr == 2'd1);

  // FSM sees CTRL as it will be after a same-cycle CPU write
  assign ctrl_eff = wr_ctrl ? wdata[CTRL_BITS-1:0] : ctrl_q;
  assign en_eff   = ctrl_eff[EN_B];
  // MODE=1x behaves as one-shot, so only 01 selects auto-reload
  assign auto_eff = (ctrl_eff[2:1] == 2'b01);
  assign auto_q   = (ctrl_q[2:1] == 2'b01);

  // Next-state, count and flag logic
  always_comb begin
    state_nxt = state;
    count_nxt = count_q;
    ctrl_nxt  = ctrl_eff;
    flag_nxt  = wr_ctrl ? 1'b0 : irq_flag;
    case (state)
      IDLE: if (en_eff) state_nxt = LOAD;
      LOAD: begin
        // load happens even if EN is cleared this cycle; CNT exits next
        count_nxt = preset_q;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en_eff) begin
          state_nxt = IDLE;
        end else if (count_q > ONE) begin
          count_nxt = count_q - ONE;
        end else begin
          count_nxt = '0;
          state_nxt = INT;
        end
      end
      INT: begin
        if (auto_eff) begin
          state_nxt = en_eff ? LOAD : IDLE;
        end else begin
          state_nxt = IDLE;
          // a CPU CTRL write in this cycle wins over the expiry side effects
          if (!wr_ctrl) begin
            flag_nxt       = 1'b1;
            ctrl_nxt[EN_B] = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl_q   <= ctrl_nxt;
      count_q  <= count_nxt;
      irq_flag <= flag_nxt;
      if (wr_preset) preset_q <= wdata;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    case (addr)
      2'd0:    rdata = WIDTH'(ctrl_q);
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = '0;
    endcase
  end

  // Level irq in one-shot, one-cycle pulse in auto-reload
  assign irq = ctrl_q[IM_B] & (auto_q ? (state == INT) : irq_flag);

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer with an expected-value queue scoreboard.
module tb_bus_timer;
  logic        clk = 1'b0;
  logic        reset;
  logic        sel, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  bus_timer #(.WIDTH(32), .CTRL_BITS(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
    cyc(2);
    // reset state
    rd("rst_ctrl", 2'd0, 32'd0);
    rd("rst_preset", 2'd1, 32'd0);
    rd("rst_count", 2'd2, 32'd0);
    rd("rst_rsvd", 2'd3, 32'd0);
    chk_irq("rst_irq", 1'b0);
    reset = 1'b1;
    cyc(1);

    // one-shot with irq
    wr(2'd1, 32'd3);
    wr(2'd0, 32'b1001);
    rd("os_load", 2'd2, 32'd0);
    cyc(1); rd("os_c3", 2'd2, 32'd3);
    cyc(1); rd("os_c2", 2'd2, 32'd2);
    cyc(1); rd("os_c1", 2'd2, 32'd1);
    cyc(1); rd("os_c0", 2'd2, 32'd0); chk_irq("os_irq_int", 1'b0);
    cyc(1); chk_irq("os_irq_rise", 1'b1); rd("os_ctrl", 2'd0, 32'b1000);
    cyc(2); chk_irq("os_irq_hold", 1'b1);
    wr(2'd0, 32'd0);
    chk_irq("os_irq_clr", 1'b0);

    // auto-reload, PRESET=2 -> pulse every 4 cycles
    wr(2'd1, 32'd2);
    wr(2'd0, 32'b1011);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk_irq($sformatf("ar_irq_%0d", k), (k % 4) == 3);
    end
    rd("ar_ctrl", 2'd0, 32'b1011);
    // EN=0 written in the LOAD cycle: load still happens, then IDLE
    wr(2'd0, 32'd0);
    cyc(1); rd("ar_stop_load", 2'd2, 32'd2);
    cyc(1); rd("ar_stop_hold", 2'd2, 32'd2);

    // masked one-shot
    wr(2'd1, 32'd1);
    wr(2'd0, 32'b0001);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk_irq($sformatf("mk_irq_%0d", k), 1'b0);
    end
    rd("mk_ctrl", 2'd0, 32'd0);
    rd("mk_count", 2'd2, 32'd0);
    check("mk_flag_set", {31'b0, dut.irq_flag}, 32'd1);
    wr(2'd0, 32'b1000);
    chk_irq("mk_irq_unmask", 1'b0);
    check("mk_flag_clr", {31'b0, dut.irq_flag}, 32'd0);

    // MODE=10 behaves as one-shot; PRESET=0 boundary
    wr(2'd1, 32'd0);
    wr(2'd0, 32'b1101);
    cyc(1); rd("m2_count", 2'd2, 32'd0);
    cyc(1); chk_irq("m2_irq_int", 1'b0);
    cyc(1); chk_irq("m2_irq", 1'b1); rd("m2_ctrl", 2'd0, 32'b1100);
    wr(2'd0, 32'd0);

    // disable mid-count, then re-enable
    wr(2'd1, 32'd10);
    wr(2'd0, 32'b0001);
    cyc(5); rd("dis_c6", 2'd2, 32'd6);
    wr(2'd0, 32'd0);
    rd("dis_hold0", 2'd2, 32'd6);
    cyc(2); rd("dis_hold2", 2'd2, 32'd6);
    wr(2'd0, 32'b0001);
    cyc(1); rd("dis_reload", 2'd2, 32'd10);

    // collisions and ignored writes
    wr(2'd1, 32'd7);
    rd("col_preset_cnt", 2'd2, 32'd9);
    wr(2'd2, 32'hFFFF);
    rd("col_count_wr", 2'd2, 32'd8);
    wr(2'd3, 32'h55);
    rd("col_rsvd", 2'd3, 32'd0);
    rd("col_preset", 2'd1, 32'd7);
    cyc(7); rd("col_zero", 2'd2, 32'd0);
    wr(2'd0, 32'b1001);  // lands in the INT cycle
    chk_irq("col_int_irq", 1'b0);
    rd("col_int_ctrl", 2'd0, 32'b1001);
    cyc(2); rd("col_new_preset", 2'd2, 32'd7);

    // asynchronous reset mid-count
    cyc(2); rd("ar5_count", 2'd2, 32'd5);
    reset = 1'b0;
    #1;
    rd("arst_count", 2'd2, 32'd0);
    rd("arst_ctrl", 2'd0, 32'd0);
    chk_irq("arst_irq", 1'b0);
    cyc(1); rd("arst_hold", 2'd2, 32'd0);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
